// File: rtl/snake_pkg.sv
// Shared types and defaults for the snake body store and its scan port.
package snake_pkg;

    localparam int WIDTH_DEFAULT    = 2;
    localparam int DEPTH_DEFAULT    = 220;
    localparam int INIT_LEN_DEFAULT = 3;

    // One body segment entry at the default width.
    typedef logic [WIDTH_DEFAULT-1:0] seg_t;

    // Scan port sequencing: idle (pushes allowed) or streaming entries.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_e;

endpackage

// File: rtl/shiftreg_store.sv
// Body segment storage: a DEPTH-entry shift array, head at index 0, with
// read ports for the scan index and the tail index.
module shiftreg_store #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 220,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] shift_data,
    input  logic [LEN_W-1:0] scan_idx,
    input  logic [LEN_W-1:0] tail_idx,
    output logic [WIDTH-1:0] head,
    output logic [WIDTH-1:0] scan_data,
    output logic [WIDTH-1:0] tail_data
);

    // Array index width; LEN_W is never narrower because it also counts DEPTH.
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [WIDTH-1:0] scan_data_s;
    logic [WIDTH-1:0] tail_data_s;

    // Shift array: clear wipes every entry, a push moves everything one slot tailward.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (shift_en) begin
            mem_r[0] <= shift_data;
            for (int i = 1; i < DEPTH; i++) begin
                mem_r[i] <= mem_r[i-1];
            end
        end
    end

    // Scan read mux; an out-of-range index reads as zero rather than aliasing.
    always_comb begin
        scan_data_s = '0;
        if (scan_idx < LEN_W'(DEPTH)) begin
            scan_data_s = mem_r[scan_idx[IDX_W-1:0]];
        end else begin
            scan_data_s = '0;
        end
    end

    // Tail read mux, same out-of-range protection as the scan port.
    always_comb begin
        tail_data_s = '0;
        if (tail_idx < LEN_W'(DEPTH)) begin
            tail_data_s = mem_r[tail_idx[IDX_W-1:0]];
        end else begin
            tail_data_s = '0;
        end
    end

    assign head      = mem_r[0];
    assign scan_data = scan_data_s;
    assign tail_data = tail_data_s;

endmodule

// File: rtl/shiftreg_scan.sv
// Snake body shift register with push handshake, deferred grow, tail-drop
// reporting and a head-to-tail ready/valid scan stream.
module shiftreg_scan
    import snake_pkg::*;
#(
    parameter int WIDTH    = $bits(seg_t),
    parameter int DEPTH    = DEPTH_DEFAULT,
    parameter int INIT_LEN = INIT_LEN_DEFAULT,
    localparam int LEN_W   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             shift_valid,
    output logic             shift_ready,
    input  logic [WIDTH-1:0] shift_data,
    input  logic             grow,
    output logic [LEN_W-1:0] len,
    output logic [WIDTH-1:0] head,
    output logic [WIDTH-1:0] tail,
    output logic             tail_drop_valid,
    output logic [WIDTH-1:0] tail_drop_data,
    input  logic             scan_start,
    output logic             scan_busy,
    output logic             scan_valid,
    input  logic             scan_ready,
    output logic [WIDTH-1:0] scan_data,
    output logic             scan_last
);

    localparam logic [LEN_W-1:0] LEN_INIT = LEN_W'(INIT_LEN);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(DEPTH);

    scan_state_e      state_r;
    scan_state_e      state_nxt_s;
    logic [LEN_W-1:0] idx_r;
    logic [LEN_W-1:0] idx_nxt_s;
    logic [LEN_W-1:0] len_r;
    logic [LEN_W-1:0] len_nxt_s;
    logic             grow_pending_r;
    logic             grow_pending_nxt_s;
    logic             drop_valid_r;
    logic [WIDTH-1:0] drop_data_r;
    logic             push_s;
    logic             grow_eff_s;
    logic             drop_s;
    logic             ready_s;
    logic [LEN_W-1:0] last_idx_s;
    logic [WIDTH-1:0] tail_s;
    logic [WIDTH-1:0] head_s;
    logic [WIDTH-1:0] scan_data_s;

    // Pushes only while idle, so the length is frozen for the whole scan.
    assign ready_s    = (state_r == IDLE) && !clear;
    assign push_s     = shift_valid && ready_s;
    assign grow_eff_s = grow_pending_r || grow;
    assign last_idx_s = len_r - LEN_W'(1);

    shiftreg_store #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .LEN_W (LEN_W)
    ) u_store (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .shift_en   (push_s),
        .shift_data (shift_data),
        .scan_idx   (idx_r),
        .tail_idx   (last_idx_s),
        .head       (head_s),
        .scan_data  (scan_data_s),
        .tail_data  (tail_s)
    );

    // Length / grow bookkeeping: a push consumes any pending grow, otherwise the tail drops.
    always_comb begin
        len_nxt_s          = len_r;
        grow_pending_nxt_s = grow_pending_r;
        drop_s             = 1'b0;
        if (push_s) begin
            grow_pending_nxt_s = 1'b0;
            if (grow_eff_s) begin
                if (len_r < LEN_MAX) begin
                    len_nxt_s = len_r + LEN_W'(1);
                end else begin
                    drop_s = 1'b1;
                end
            end else begin
                drop_s = 1'b1;
            end
        end else if (grow) begin
            grow_pending_nxt_s = 1'b1;
        end else begin
            grow_pending_nxt_s = grow_pending_r;
        end
    end

    // Scan FSM next state: start from idle, advance on each accepted beat.
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        case (state_r)
            IDLE: begin
                if (scan_start) begin
                    state_nxt_s = SCAN;
                    idx_nxt_s   = '0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SCAN: begin
                if (scan_ready) begin
                    if (idx_r == last_idx_s) begin
                        state_nxt_s = IDLE;
                        idx_nxt_s   = '0;
                    end else begin
                        idx_nxt_s = idx_r + LEN_W'(1);
                    end
                end else begin
                    idx_nxt_s = idx_r;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                idx_nxt_s   = '0;
            end
        endcase
    end

    // Control state registers; clear restores the reset image.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= IDLE;
            idx_r          <= '0;
            len_r          <= LEN_INIT;
            grow_pending_r <= 1'b0;
        end else if (clear) begin
            state_r        <= IDLE;
            idx_r          <= '0;
            len_r          <= LEN_INIT;
            grow_pending_r <= 1'b0;
        end else begin
            state_r        <= state_nxt_s;
            idx_r          <= idx_nxt_s;
            len_r          <= len_nxt_s;
            grow_pending_r <= grow_pending_nxt_s;
        end
    end

    // Tail-drop report: one-cycle pulse carrying the pre-push tail entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_valid_r <= 1'b0;
            drop_data_r  <= '0;
        end else if (clear) begin
            drop_valid_r <= 1'b0;
            drop_data_r  <= '0;
        end else begin
            drop_valid_r <= drop_s;
            if (drop_s) begin
                drop_data_r <= tail_s;
            end
        end
    end

    assign shift_ready     = ready_s;
    assign len             = len_r;
    assign head            = head_s;
    assign tail            = tail_s;
    assign tail_drop_valid = drop_valid_r;
    assign tail_drop_data  = drop_data_r;
    assign scan_busy       = (state_r == SCAN);
    assign scan_valid      = (state_r == SCAN);
    assign scan_data       = scan_data_s;
    assign scan_last       = (state_r == SCAN) && (idx_r == last_idx_s);

endmodule
